// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit with request/ack data bus
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_rd              destination register from EX/MEM
//   mem_alu_output      ALU result, byte address for loads/stores
//   mem_rdata2          store source data
//   mem_pc_plus_4       link value
//   mem_imm             immediate (LUI path)
//   mem_funct3          access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   mem_regwrite        register write enable
//   mem_memwrite        store
//   mem_memtoreg        write-back select: 00 ALU, 01 load, 10 pc+4, 11 imm
//   dbus_req/we/addr/wstrb/wdata  registered bus request fields
//   dbus_rdata, dbus_ack          read word and one-cycle completion pulse
//   stall               combinational pipeline hold
//   wb_rd, wb_regwrite, wb_wdata  registered write-back outputs
//   misalign            registered one-cycle misaligned-access pulse
module mem_stage_lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_alu_output,
   input  logic [31:0] mem_rdata2,
   input  logic [31:0] mem_pc_plus_4,
   input  logic [31:0] mem_imm,
   input  logic [2:0]  mem_funct3,
   input  logic        mem_regwrite,
   input  logic        mem_memwrite,
   input  logic [1:0]  mem_memtoreg,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_wstrb,
   output logic [31:0] dbus_wdata,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic        stall,
   output logic [4:0]  wb_rd,
   output logic        wb_regwrite,
   output logic [31:0] wb_wdata,
   output logic        misalign
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic        is_load;
   logic        mem_op;
   logic        misaligned;
   logic [1:0]  byte_off;
   logic [3:0]  strb;
   logic [31:0] store_data;
   logic [31:0] lane;
   logic [31:0] load_data;
   logic [31:0] wb_value;
   logic        issue;
   logic        mis_pulse;
   logic        capture;

   // Undefined funct3 codes fall through to word size.
   assign is_byte    = (mem_funct3 == 3'b000) || (mem_funct3 == 3'b100);
   assign is_half    = (mem_funct3 == 3'b001) || (mem_funct3 == 3'b101);
   assign is_word    = !is_byte && !is_half;
   assign is_load    = (mem_memtoreg == 2'b01);
   assign mem_op     = is_load || mem_memwrite;
   assign byte_off   = mem_alu_output[1:0];
   assign misaligned = (is_half && byte_off[0]) || (is_word && (byte_off != 2'b00));

   always_comb begin
      strb       = 4'b1111;
      store_data = mem_rdata2;
      if (is_byte) begin
         strb       = 4'b0001 << byte_off;
         store_data = {4{mem_rdata2[7:0]}};
      end else if (is_half) begin
         strb       = byte_off[1] ? 4'b1100 : 4'b0011;
         store_data = {2{mem_rdata2[15:0]}};
      end
   end

   // Shift the addressed byte/half down to bit 0, then extend; funct3[2] marks unsigned.
   assign lane = dbus_rdata >> {byte_off, 3'b000};

   always_comb begin
      load_data = lane;
      if (is_byte) begin
         load_data = mem_funct3[2] ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end else if (is_half) begin
         load_data = mem_funct3[2] ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      end
   end

   always_comb begin
      case (mem_memtoreg)
         2'b00:   wb_value = mem_alu_output;
         2'b01:   wb_value = load_data;
         2'b10:   wb_value = mem_pc_plus_4;
         default: wb_value = mem_imm;
      endcase
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      issue     = 1'b0;
      mis_pulse = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op) begin
               if (misaligned) begin
                  mis_pulse = 1'b1;
               end else begin
                  stall     = 1'b1;
                  issue     = 1'b1;
                  state_nxt = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (dbus_ack) begin
               state_nxt = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stall edges insert a bubble; a misaligned op is dropped without a write.
   assign capture = !stall && !mis_pulse;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         dbus_req    <= 1'b0;
         dbus_we     <= 1'b0;
         dbus_addr   <= 32'd0;
         dbus_wstrb  <= 4'd0;
         dbus_wdata  <= 32'd0;
         wb_rd       <= 5'd0;
         wb_regwrite <= 1'b0;
         wb_wdata    <= 32'd0;
         misalign    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (issue) begin
            dbus_req   <= 1'b1;
            dbus_we    <= mem_memwrite;
            dbus_addr  <= {mem_alu_output[31:2], 2'b00};
            dbus_wstrb <= strb;
            dbus_wdata <= store_data;
         end else if ((state == ACCESS) && dbus_ack) begin
            dbus_req <= 1'b0;
         end
         misalign    <= mis_pulse;
         wb_rd       <= mem_rd;
         wb_wdata    <= wb_value;
         wb_regwrite <= capture && mem_regwrite;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  mem_rd;
   logic [31:0] mem_alu_output, mem_rdata2, mem_pc_plus_4, mem_imm;
   logic [2:0]  mem_funct3;
   logic        mem_regwrite, mem_memwrite;
   logic [1:0]  mem_memtoreg;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]  dbus_wstrb;
   logic        dbus_ack;
   logic        stall;
   logic [4:0]  wb_rd;
   logic        wb_regwrite;
   logic [31:0] wb_wdata;
   logic        misalign;

   always #5 clk = ~clk;

   mem_stage_lsu dut (
      .clk(clk), .rst_n(rst_n),
      .mem_rd(mem_rd), .mem_alu_output(mem_alu_output), .mem_rdata2(mem_rdata2),
      .mem_pc_plus_4(mem_pc_plus_4), .mem_imm(mem_imm), .mem_funct3(mem_funct3),
      .mem_regwrite(mem_regwrite), .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
      .dbus_ack(dbus_ack), .stall(stall), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .wb_wdata(wb_wdata), .misalign(misalign)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rdata2;
      logic [31:0] pc4;
      logic [31:0] imm;
      logic [2:0]  f3;
      logic        rw;
      logic        mw;
      logic [1:0]  mtr;
      int          w;
      logic [31:0] rdata;
   } op_t;

   int checks = 0;
   int errors = 0;
   int stall_cnt = 0;
   bit run = 1'b0;

   // Expectations for the current cycle (combinational + bus registers).
   logic        e_stall, e_req, e_we;
   logic [31:0] e_addr, e_wdata;
   logic [3:0]  e_strb;
   // Expectations for write-back registers: r_* now, p_* after the next edge.
   logic        r_wbre, r_mis, r_cap, p_wbre, p_mis, p_cap;
   logic [4:0]  r_rd, p_rd;
   logic [31:0] r_val, p_val;

   function automatic int sz(logic [2:0] f);
      case (f)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic bit is_mem(op_t o);
      return (o.mtr == 2'b01) || o.mw;
   endfunction

   function automatic bit misal(op_t o);
      return (int'(o.alu[1:0]) % sz(o.f3)) != 0;
   endfunction

   function automatic logic [3:0] m_strb(op_t o);
      int m;
      m = ((1 << sz(o.f3)) - 1) << int'(o.alu[1:0]);
      return m[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(op_t o);
      case (sz(o.f3))
         1:       return {24'd0, o.rdata2[7:0]} * 32'h0101_0101;
         2:       return {16'd0, o.rdata2[15:0]} * 32'h0001_0001;
         default: return o.rdata2;
      endcase
   endfunction

   function automatic logic [31:0] m_load(logic [2:0] f, logic [31:0] addr, logic [31:0] word);
      logic [31:0] v;
      bit          sgn;
      v   = word >> (8 * int'(addr[1:0]));
      sgn = (f == 3'b000) || (f == 3'b001);
      case (sz(f))
         1: begin
            v = v & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
         end
         2: begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
         end
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] m_wb(op_t o, logic [31:0] word);
      case (o.mtr)
         2'b00:   return o.alu;
         2'b01:   return m_load(o.f3, o.alu, word);
         2'b10:   return o.pc4;
         default: return o.imm;
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(op_t o);
      mem_rd         = o.rd;
      mem_alu_output = o.alu;
      mem_rdata2     = o.rdata2;
      mem_pc_plus_4  = o.pc4;
      mem_imm        = o.imm;
      mem_funct3     = o.f3;
      mem_regwrite   = o.rw;
      mem_memwrite   = o.mw;
      mem_memtoreg   = o.mtr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      r_wbre = p_wbre; r_mis = p_mis; r_cap = p_cap; r_rd = p_rd; r_val = p_val;
   endtask

   task automatic set_bubble();
      p_wbre = 1'b0; p_mis = 1'b0; p_cap = 1'b0;
   endtask

   // Presents one op to the stage, acting as upstream pipeline and bus slave.
   task automatic run_op(op_t o);
      if (is_mem(o) && !misal(o)) begin
         for (int k = 0; k <= o.w + 1; k++) begin
            next_cycle();
            drive(o);
            dbus_ack   = (k == o.w + 1);
            dbus_rdata = (k == o.w + 1) ? o.rdata : $urandom;
            e_stall    = (k <= o.w);
            e_req      = (k > 0);
            e_we       = o.mw;
            e_addr     = {o.alu[31:2], 2'b00};
            e_strb     = m_strb(o);
            e_wdata    = m_wdata(o);
            if (k == o.w + 1) begin
               p_wbre = o.rw; p_mis = 1'b0; p_cap = 1'b1;
               p_rd = o.rd; p_val = m_wb(o, o.rdata);
            end else begin
               set_bubble();
            end
         end
      end else begin
         next_cycle();
         drive(o);
         dbus_ack   = 1'($urandom_range(0, 1));
         dbus_rdata = $urandom;
         e_stall    = 1'b0;
         e_req      = 1'b0;
         if (is_mem(o)) begin
            p_wbre = 1'b0; p_mis = 1'b1; p_cap = 1'b0;
         end else begin
            p_wbre = o.rw; p_mis = 1'b0; p_cap = 1'b1;
            p_rd = o.rd; p_val = m_wb(o, 32'd0);
         end
      end
   endtask

   function automatic op_t mk(logic [4:0] rd, logic [31:0] alu, logic [31:0] rdata2, logic [2:0] f3,
                              logic rw, logic mw, logic [1:0] mtr, int w, logic [31:0] rdata);
      op_t o;
      o.rd = rd; o.alu = alu; o.rdata2 = rdata2; o.pc4 = 32'h0000_4004; o.imm = 32'h1234_5000;
      o.f3 = f3; o.rw = rw; o.mw = mw; o.mtr = mtr; o.w = w; o.rdata = rdata;
      return o;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      logic [2:0] codes [8];
      int kind;
      codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      o.rd = 5'($urandom); o.alu = $urandom; o.rdata2 = $urandom;
      o.pc4 = $urandom; o.imm = $urandom; o.rdata = $urandom;
      o.f3 = codes[$urandom_range(0, 7)];
      o.w = $urandom_range(0, 3);
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
         o.mw = 1'b0; o.rw = 1'b1;
         case ($urandom_range(0, 2))
            0:       o.mtr = 2'b00;
            1:       o.mtr = 2'b10;
            default: o.mtr = 2'b11;
         endcase
      end else if (kind == 1) begin
         o.mw = 1'b0; o.rw = 1'b1; o.mtr = 2'b01;
      end else begin
         o.mw = 1'b1; o.rw = ($urandom_range(0, 3) == 0); o.mtr = 2'b00;
      end
      return o;
   endfunction

   always @(negedge clk) begin
      if (run) begin
         stall_cnt = stall_cnt + int'(stall);
         chk("stall", 32'(stall), 32'(e_stall));
         chk("dbus_req", 32'(dbus_req), 32'(e_req));
         if (e_req) begin
            chk("dbus_we", 32'(dbus_we), 32'(e_we));
            chk("dbus_addr", dbus_addr, e_addr);
            if (e_we) begin
               chk("dbus_wstrb", 32'(dbus_wstrb), 32'(e_strb));
               chk("dbus_wdata", dbus_wdata, e_wdata);
            end
         end
         chk("wb_regwrite", 32'(wb_regwrite), 32'(r_wbre));
         chk("misalign", 32'(misalign), 32'(r_mis));
         if (r_cap) begin
            chk("wb_rd", 32'(wb_rd), 32'(r_rd));
            chk("wb_wdata", wb_wdata, r_val);
         end
      end
   end

   op_t nop0;
   op_t o;
   int  s0;

   initial begin
      nop0 = mk(5'd0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 2'b00, 0, 32'd0);
      nop0.pc4 = 32'd0; nop0.imm = 32'd0;
      drive(nop0);
      dbus_ack = 1'b0; dbus_rdata = 32'd0;
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_addr = 0; e_strb = 0; e_wdata = 0;
      r_wbre = 1'b0; r_mis = 1'b0; r_cap = 1'b1; r_rd = 5'd0; r_val = 32'd0;
      p_wbre = 1'b0; p_mis = 1'b0; p_cap = 1'b1; p_rd = 5'd0; p_val = 32'd0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(dbus_req), 32'd0);
      chk("rst_we", 32'(dbus_we), 32'd0);
      chk("rst_addr", dbus_addr, 32'd0);
      chk("rst_wstrb", 32'(dbus_wstrb), 32'd0);
      chk("rst_wdata", dbus_wdata, 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
      chk("rst_wb_wdata", wb_wdata, 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      rst_n = 1'b1;
      run = 1'b1;

      // Pin the model with hand-computed values.
      chk("model_lb", m_load(3'b000, 32'h200, 32'h80FF_7F80), 32'hFFFF_FF80);
      chk("model_lbu", m_load(3'b100, 32'h201, 32'h80FF_7F80), 32'h0000_007F);
      chk("model_lh", m_load(3'b001, 32'h202, 32'h80FF_7F80), 32'hFFFF_80FF);
      chk("model_lhu", m_load(3'b101, 32'h202, 32'h80FF_7F80), 32'h0000_80FF);
      chk("model_lw", m_load(3'b010, 32'h200, 32'h80FF_7F80), 32'h80FF_7F80);
      o = mk(5'd1, 32'h103, 32'hAABB_CCDD, 3'b000, 1'b0, 1'b1, 2'b00, 3, 32'd0);
      chk("model_sb_strb", 32'(m_strb(o)), 32'h8);
      chk("model_sb_wdata", m_wdata(o), 32'hDDDD_DDDD);

      // ALU passthrough.
      run_op(mk(5'd5, 32'h0000_1234, 32'd0, 3'b010, 1'b1, 1'b0, 2'b00, 0, 32'd0));
      run_op(nop0);
      chk("alu_wb_rd", 32'(wb_rd), 32'd5);
      chk("alu_wb_wdata", wb_wdata, 32'h1234);
      chk("alu_wb_regwrite", 32'(wb_regwrite), 32'd1);

      // SB with three wait cycles: four stall cycles.
      @(negedge clk);
      s0 = stall_cnt;
      run_op(o);
      @(negedge clk);
      chk("sb_stall_cycles", 32'(stall_cnt - s0), 32'd4);

      // Loads of 0x80FF7F80.
      run_op(mk(5'd6, 32'h200, 32'd0, 3'b000, 1'b1, 1'b0, 2'b01, 0, 32'h80FF_7F80));
      run_op(mk(5'd7, 32'h201, 32'd0, 3'b100, 1'b1, 1'b0, 2'b01, 1, 32'h80FF_7F80));
      run_op(mk(5'd8, 32'h202, 32'd0, 3'b001, 1'b1, 1'b0, 2'b01, 0, 32'h80FF_7F80));
      run_op(mk(5'd9, 32'h202, 32'd0, 3'b101, 1'b1, 1'b0, 2'b01, 2, 32'h80FF_7F80));
      run_op(mk(5'd10, 32'h200, 32'd0, 3'b010, 1'b1, 1'b0, 2'b01, 0, 32'h80FF_7F80));
      run_op(nop0);
      chk("lw_wb_wdata", wb_wdata, 32'h80FF_7F80);

      // Misaligned LW.
      run_op(mk(5'd11, 32'h102, 32'd0, 3'b010, 1'b1, 1'b0, 2'b01, 0, 32'd0));
      run_op(nop0);
      chk("mis_pulse", 32'(misalign), 32'd1);
      chk("mis_wb_regwrite", 32'(wb_regwrite), 32'd0);

      // Back-to-back SW then LW, zero wait states.
      @(negedge clk);
      s0 = stall_cnt;
      run_op(mk(5'd0, 32'h300, 32'h1122_3344, 3'b010, 1'b0, 1'b1, 2'b00, 0, 32'd0));
      run_op(mk(5'd12, 32'h304, 32'd0, 3'b010, 1'b1, 1'b0, 2'b01, 0, 32'hCAFE_F00D));
      @(negedge clk);
      chk("b2b_stall_cycles", 32'(stall_cnt - s0), 32'd2);

      for (int i = 0; i < 300; i++) run_op(rand_op());

      // Reset while an access is outstanding.
      o = mk(5'd13, 32'h400, 32'd0, 3'b010, 1'b1, 1'b0, 2'b01, 5, 32'd0);
      next_cycle();
      drive(o);
      dbus_ack = 1'b0;
      e_stall = 1'b1; e_req = 1'b0;
      set_bubble();
      next_cycle();
      e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h400;
      @(negedge clk);
      #1;
      run = 1'b0;
      drive(nop0);
      rst_n = 1'b0;
      #1;
      chk("midrst_req", 32'(dbus_req), 32'd0);
      chk("midrst_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dbus_ack = 1'b1;
      dbus_rdata = $urandom;
      #1;
      chk("late_ack_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      dbus_ack = 1'b0;
      chk("late_ack_wb_regwrite", 32'(wb_regwrite), 32'd0);
      chk("late_ack_req", 32'(dbus_req), 32'd0);
      r_wbre = 1'b0; r_mis = 1'b0; r_cap = 1'b1; r_rd = 5'd0; r_val = 32'd0;
      p_wbre = 1'b0; p_mis = 1'b0; p_cap = 1'b1; p_rd = 5'd0; p_val = 32'd0;
      e_stall = 1'b0; e_req = 1'b0;
      run = 1'b1;

      for (int i = 0; i < 100; i++) run_op(rand_op());
      run_op(nop0);
      @(negedge clk);
      #1;
      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit that consumes the EX/MEM pipeline register outputs and drives a request/acknowledge data bus. It computes byte strobes and store data, sign- or zero-extends load data, and stalls the pipeline while an access is outstanding. It also registers the write-back value, destination and write enable for the WB stage.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_rd`  in  5  destination register from EX/MEM
- `mem_alu_output`  in  32  ALU result; this is the byte address for loads and stores
- `mem_rdata2`  in  32  store source data
- `mem_pc_plus_4`  in  32  link value
- `mem_imm`  in  32  immediate (LUI path)
- `mem_funct3`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `mem_regwrite`  in  1  register write enable
- `mem_memwrite`  in  1  store
- `mem_memtoreg`  in  2  write-back select: 00 ALU, 01 load data (this is a load), 10 pc+4, 11 imm
- `dbus_req`  out  1  access request (registered)
- `dbus_we`  out  1  1 = write
- `dbus_addr`  out  32  word address, `{mem_alu_output[31:2],2'b00}`
- `dbus_wstrb`  out  4  byte enables
- `dbus_wdata`  out  32  lane-aligned store data
- `dbus_rdata`  in  32  read word, valid when `dbus_ack` = 1
- `dbus_ack`  in  1  one-cycle completion pulse
- `stall`  out  1  combinational; while high, upstream holds PC, IF/ID, ID/EX and EX/MEM
- `wb_rd`  out  5  registered destination
- `wb_regwrite`  out  1  registered write enable
- `wb_wdata`  out  32  registered write-back value
- `misalign`  out  1  registered one-cycle pulse for a misaligned access

## Operation
- Operation types:
  - mem_op = load (memtoreg = 01) or store (memwrite = 1).
  - Misaligned = halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
- FSM has two states, IDLE and ACCESS.
  - IDLE, aligned mem_op: register `dbus_req`=1 with `dbus_we`/`dbus_addr`/`dbus_wstrb`/`dbus_wdata` → ACCESS. `stall`=1 this cycle.
  - IDLE, misaligned mem_op: no bus access; stay in IDLE; `stall`=0; next edge `misalign`=1, `wb_regwrite`=0.
  - IDLE, non-mem op: `stall`=0; WB registers capture at the next edge.
  - ACCESS, `dbus_ack`=0: hold `dbus_req` and all bus fields stable; `stall`=1.
  - ACCESS, `dbus_ack`=1: `stall`=0; next edge `dbus_req`=0 → IDLE; WB registers capture the result, using `dbus_rdata` for loads.
- `dbus_ack` in IDLE is ignored.
- Store strobes and data, with a = addr[1:0]:
  - SB: strb = 0001 << a; wdata = rdata2[7:0] replicated ×4.
  - SH: strb = 0011 << {a[1],0}; wdata = rdata2[15:0] replicated ×2.
  - SW: strb = 1111; wdata = rdata2.
- Load extract from `dbus_rdata`: select the byte or half by a, then apply funct3 extension (B/H sign-extend, BU/HU zero-extend, W unchanged).
- Write-back select: memtoreg 00 → mem_alu_output, 01 → extracted load, 10 → mem_pc_plus_4, 11 → mem_imm.
- Any edge where `stall`=1 loads a bubble into WB: `wb_regwrite`=0; `wb_rd` and `wb_wdata` are don't-care but still defined.
- Stores write `wb_regwrite` = mem_regwrite, which is normally 0.
- Undefined funct3 values (011, 110, 111) are treated as W.

## Timing
- Reset (async, `rst_n`=0): state IDLE, `dbus_req`=0, `dbus_we`=0, `dbus_addr`=0, `dbus_wstrb`=0, `dbus_wdata`=0, `wb_rd`=0, `wb_regwrite`=0, `wb_wdata`=0, `misalign`=0.
  - `stall` evaluates to 0 unless a mem_op is present in IDLE.
- Reset during ACCESS drops `dbus_req` immediately; a late `dbus_ack` after release is ignored.
- Latencies:
  - Non-mem op: 1 cycle to WB.
  - Load/store with a zero-wait-state bus (ack on the first ACCESS cycle): 2 cycles, stall high for 1 cycle.
  - Each ack wait cycle adds 1 cycle.
- `dbus_req` rises on the edge after IDLE detects the op; it falls on the edge after `dbus_ack`.
- Back-to-back mem ops: the second op's IDLE decode cycle immediately follows the completing ack edge, so there is no dead cycle beyond the IDLE issue cycle.

## Test plan
- **ALU passthrough:** memtoreg=00, alu=0x0000_1234, rd=5, regwrite=1 → next edge `wb_rd`=5, `wb_wdata`=0x1234, `wb_regwrite`=1; `stall` never high.
- **SB:** addr=0x103, rdata2=0xAABBCCDD → `dbus_addr`=0x100, `dbus_wstrb`=1000, `dbus_wdata`=0xDDDDDDDD, `dbus_we`=1.
  - With ack 3 cycles after req: `stall` high for 4 cycles, req low the edge after ack.
- **Loads, rdata=0x80FF_7F80:**
  - LB @0x200 → 0xFFFFFF80.
  - LBU @0x201 → 0x0000007F.
  - LH @0x202 → 0xFFFF80FF.
  - LHU @0x202 → 0x000080FF.
  - LW → 0x80FF7F80.
- **Misaligned:** LW @0x102 → no `dbus_req`, `stall`=0, `misalign` pulses 1 cycle, `wb_regwrite`=0.
- **Reset mid-access:** assert `rst_n`=0 while in ACCESS → `dbus_req`=0 at once; after release, an ack pulse causes no WB write and `stall`=0.
- **Back-to-back SW then LW with ack on the first ACCESS cycle:** 2 cycles each, 4 cycles total; `wb_regwrite` is 0 on the stall edges and carries the load value on the final edge.
